// File: rtl/datamem_pkg.sv
// Shared types for the data memory arbiter: access sizes, FSM states, the captured
// request record and the acceptance-time fault rule.
package datamem_pkg;

  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic        wen;
    size_e       size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Misaligned, illegal size or outside the 2^ADDR_W byte window.
  function automatic logic is_fault(size_e size, logic [31:0] addr);
    logic f;
    f = 1'b0;
    case (size)
      SZ_H:    f = addr[0];
      SZ_W:    f = |addr[1:0];
      SZ_X:    f = 1'b1;
      default: f = 1'b0;
    endcase
    if (|addr[31:ADDR_W]) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// Request/response handshake and memory-side bus of the data memory arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface datamem_arbiter_if;
  import datamem_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_wen;
  logic [1:0][1:0]   req_size;
  logic [1:0]        req_signed;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;

  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_en;
  logic              mem_wen;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_wen, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_wen, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/datamem_lane_fmt.sv
// Combinational lane formatter: byte enables, replicated store data and
// lane extraction with sign/zero extension for loads.
module datamem_lane_fmt
  import datamem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = rdata[8*gi +: 8];

      assign be[gi] = (size == SZ_W) ||
                      ((size == SZ_B) && (addr_lo == 2'(gi))) ||
                      ((size == SZ_H) && (addr_lo[1] == 1'(gi / 2)));

      // Narrow stores are replicated so every enabled lane sees the right byte.
      assign wdata_lanes[8*gi +: 8] = (size == SZ_B) ? wdata[7:0] :
                                      (size == SZ_H) ? wdata[8*(gi % 2) +: 8] :
                                                       wdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[addr_lo];
  assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rdata_ext = rdata;
    case (size)
      SZ_B:    rdata_ext = {{24{sgn & sel_byte[7]}}, sel_byte};
      SZ_H:    rdata_ext = {{16{sgn & sel_half[15]}}, sel_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-requester arbiter for the 128 KiB byte-addressed data memory, one access in flight.
// Define DATAMEM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module datamem_arbiter
  import datamem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  datamem_arbiter_if.slave bus
);

  state_e            state_reg, state_next;
  req_t              req_reg, req_next;
  logic              id_reg, id_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_wen_reg, mem_wen_next;
  logic [3:0]        mem_be_reg, mem_be_next;
  logic [ADDR_W-3:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;

  logic [1:0]        req_ready;
  logic              any_req;
  logic              grant_id;
  req_t              grant_req;
  req_t              fmt_req;
  logic              fmt_fault;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata;
  logic [31:0]       fmt_rdata;

  assign any_req = |bus.req_valid;

`ifdef DATAMEM_ARB_RR_EN
  logic last_grant_reg, last_grant_next;

  always_comb begin
    if (&bus.req_valid) grant_id = ~last_grant_reg;
    else                grant_id = ~bus.req_valid[0];
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (state_reg == IDLE && any_req) last_grant_next = grant_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_reg <= 1'b1;
    else        last_grant_reg <= last_grant_next;
  end
`else
  assign grant_id = ~bus.req_valid[0];
`endif

  always_comb begin
    grant_req.wen   = bus.req_wen[grant_id];
    grant_req.size  = size_e'(bus.req_size[grant_id]);
    grant_req.sgn   = bus.req_signed[grant_id];
    grant_req.addr  = bus.req_addr[grant_id];
    grant_req.wdata = bus.req_wdata[grant_id];
  end

  // The formatter sees the live request at acceptance and the captured one afterwards.
  assign fmt_req   = (state_reg == IDLE) ? grant_req : req_reg;
  assign fmt_fault = is_fault(fmt_req.size, fmt_req.addr);

  datamem_lane_fmt u_lane_fmt (
    .size        (fmt_req.size),
    .addr_lo     (fmt_req.addr[1:0]),
    .sgn         (fmt_req.sgn),
    .wdata       (fmt_req.wdata),
    .rdata       (bus.mem_rdata),
    .be          (fmt_be),
    .wdata_lanes (fmt_wdata),
    .rdata_ext   (fmt_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    id_next        = id_reg;
    mem_en_next    = mem_en_reg;
    mem_wen_next   = mem_wen_reg;
    mem_be_next    = mem_be_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    req_ready      = 2'b00;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          req_ready[grant_id] = 1'b1;
          req_next            = grant_req;
          id_next             = grant_id;
          if (fmt_fault) begin
            state_next     = RESP;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end else begin
            state_next     = ISSUE;
            rsp_err_next   = 1'b0;
            mem_en_next    = 1'b1;
            mem_wen_next   = grant_req.wen;
            mem_be_next    = fmt_be;
            mem_addr_next  = grant_req.addr[ADDR_W-1:2];
            mem_wdata_next = fmt_wdata;
          end
        end
      end
      ISSUE: begin
        mem_en_next  = 1'b0;
        mem_wen_next = 1'b0;
        state_next   = WAIT;
      end
      WAIT: begin
        rsp_rdata_next = req_reg.wen ? 32'h0 : fmt_rdata;
        state_next     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[id_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_reg       <= '0;
      id_reg        <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mem_be_reg    <= 4'h0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'h0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      id_reg        <= id_next;
      mem_en_reg    <= mem_en_next;
      mem_wen_reg   <= mem_wen_next;
      mem_be_reg    <= mem_be_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_reg == RESP) ? (2'b01 << id_reg) : 2'b00;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_wen   = mem_wen_reg;
  assign bus.mem_be    = mem_be_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed plus randomized bench for datamem_arbiter against a byte-array reference memory.
module tb_datamem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  datamem_arbiter_if bus ();

  datamem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory: first 1024 bytes, little-endian byte view.
  logic [7:0] ref_mem [0:1023];

  // Word-organised memory model on the DUT's memory port.
  logic [31:0] env_mem [0:255];
  logic        init_done = 1'b0;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_wen) begin
        for (int j = 0; j < 4; j++)
          if (bus.mem_be[j]) env_mem[bus.mem_addr[7:0]][8*j +: 8] <= bus.mem_wdata[8*j +: 8];
      end else begin
        bus.mem_rdata <= env_mem[bus.mem_addr[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expectations for the request currently being serviced.
  logic        cur_wen;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  int          cur_n;
  logic        exp_fault;
  logic [3:0]  exp_be;
  logic [31:0] exp_wd, exp_rd;

  function automatic logic [31:0] ref_load(logic [31:0] addr, int n, logic sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic calc_exp(input logic wen, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
    cur_wen   = wen;
    cur_size  = size;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_fault = (size == 2'd3) || ((addr % 32'(cur_n)) != 0) || (addr >= 32'h0002_0000);
    exp_be    = 4'h0;
    for (int i = 0; i < cur_n; i++) exp_be[(int'(addr[1:0]) + i) % 4] = 1'b1;
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*(j % cur_n) +: 8];
    exp_rd = (wen || exp_fault) ? 32'h0 : ref_load(addr, cur_n, sgn);
  endtask

  task automatic drive_req(input int id, input logic wen, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_wen[id]    = wen;
    bus.req_size[id]   = size;
    bus.req_signed[id] = sgn;
    bus.req_addr[id]   = addr;
    bus.req_wdata[id]  = wdata;
    bus.req_valid[id]  = 1'b1;
  endtask

  task automatic wait_ready(input int id, input string tag);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) break;
    end
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(2'b01 << id));
  endtask

  // Called #1 after the accepting edge; follows the access to retirement.
  task automatic complete(input int id, input int hold, input string tag);
    int men_k, men_cnt, rsp_k;
    logic [31:0] rd0;
    bus.req_valid[id] = 1'b0;
    bus.req_addr[id]  = $urandom;
    bus.req_wdata[id] = $urandom;
    bus.req_size[id]  = 2'($urandom);
    men_k = 0; men_cnt = 0; rsp_k = 0;
    for (int k = 1; k <= 20 && rsp_k == 0; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        men_cnt++;
        if (men_k == 0) men_k = k;
        chk({tag, ".be"}, 32'(bus.mem_be), 32'(exp_be));
        chk({tag, ".maddr"}, 32'(bus.mem_addr), cur_addr >> 2);
        chk({tag, ".mwen"}, 32'(bus.mem_wen), 32'(cur_wen));
        if (cur_wen) chk({tag, ".mwdata"}, bus.mem_wdata, exp_wd);
      end
      if (bus.rsp_valid[id]) rsp_k = k;
    end
    chk({tag, ".rsp_lat"}, 32'(rsp_k), exp_fault ? 32'd1 : 32'd3);
    chk({tag, ".men_lat"}, 32'(men_k), exp_fault ? 32'd0 : 32'd1);
    chk({tag, ".men_cnt"}, 32'(men_cnt), exp_fault ? 32'd0 : 32'd1);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(2'b01 << id));
    chk({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_fault));
    rd0 = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'(2'b01 << id));
      chk({tag, ".hold_rdata"}, bus.rsp_rdata, rd0);
      chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready[id] = 1'b1;
    chk({tag, ".hs_ready"}, 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    bus.rsp_ready[id] = 1'b0;
    if (cur_wen && !exp_fault)
      for (int i = 0; i < cur_n; i++) ref_mem[cur_addr + 32'(i)] = cur_wdata[8*i +: 8];
    $display("txn %s id=%0d wen=%0d size=%0d addr=0x%08h rdata=0x%08h err=%0d",
             tag, id, cur_wen, cur_size, cur_addr, rd0, exp_fault);
  endtask

  task automatic access(input int id, input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input string tag);
    calc_exp(wen, size, sgn, addr, wdata);
    drive_req(id, wen, size, sgn, addr, wdata);
    wait_ready(id, tag);
    @(posedge clk); #1;
    complete(id, hold, tag);
  endtask

  int          g_id  [4];
  int          g_cyc [4];
  int          n_g;
  int          r_id, r_n;
  logic        r_wen, r_sgn;
  logic [1:0]  r_size;
  logic [31:0] r_addr;

  initial begin
    bus.req_valid  = '0;
    bus.req_wen    = '0;
    bus.req_size   = '0;
    bus.req_signed = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst.mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst.mem_wen", 32'(bus.mem_wen), 32'h0);
    chk("rst.mem_be", 32'(bus.mem_be), 32'h0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk); #1;

    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, "ld_w");
    chk("ld_w.const", exp_rd, 32'hDEADBEEF);
    access(1, 1'b1, 2'b00, 1'b0, 32'h3, 32'h0000_00A5, 0, "st_b");
    chk("st_b.be_const", 32'(exp_be), 32'h8);
    access(0, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 0, "ld_bs");
    chk("ld_bs.const", exp_rd, 32'hFFFF_FFA5);
    access(0, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 0, "ld_bu");
    chk("ld_bu.const", exp_rd, 32'h0000_00A5);
    access(0, 1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 0, "mis_h");
    access(1, 1'b0, 2'b10, 1'b0, 32'h0002_0000, 32'h0, 0, "oob_w");
    access(0, 1'b1, 2'b11, 1'b0, 32'h8, 32'h1234, 0, "bad_sz");
    access(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 0, "st_h");
    access(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, "ld_hs");

    // Response back-pressure with the other requester waiting.
    calc_exp(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    drive_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    wait_ready(0, "hold");
    @(posedge clk); #1;
    drive_req(1, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    complete(0, 5, "hold");
    @(negedge clk);
    chk("hold.r1_ready", 32'(bus.req_ready), 32'h2);
    calc_exp(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    @(posedge clk); #1;
    complete(1, 0, "hold.r1");

    for (int t = 0; t < 40; t++) begin
      r_id   = int'($urandom_range(0, 1));
      r_wen  = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_n    = (r_size == 2'd0) ? 1 : (r_size == 2'd1) ? 2 : 4;
      r_addr = 32'($urandom_range(0, 255)) << 2;
      if (r_n == 1)      r_addr = r_addr + 32'($urandom_range(0, 3));
      else if (r_n == 2) r_addr = r_addr + 32'(2 * $urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       r_addr = r_addr | (32'h1 << $urandom_range(17, 31));
        1:       r_addr = r_addr + 32'($urandom_range(1, 3));
        default: ;
      endcase
      access(r_id, r_wen, r_size, r_sgn, r_addr, $urandom, int'($urandom_range(0, 3)), "rnd");
    end

    // Reset while the memory cycle is on the bus.
    calc_exp(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    drive_req(0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    wait_ready(0, "rst_mid");
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("rst_mid.issue_en", 32'(bus.mem_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_mid.mem_wen", 32'(bus.mem_wen), 32'h0);
    chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_mid.no_rsp", 32'(bus.rsp_valid), 32'h0);
    end

    // Both requesters continuously valid, responses retired immediately.
    @(posedge clk); #1;
    drive_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    drive_req(1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    bus.rsp_ready = 2'b11;
    n_g = 0;
    for (int c = 1; c <= 60 && n_g < 4; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        g_id[n_g]  = bus.req_ready[1] ? 1 : 0;
        g_cyc[n_g] = c;
        n_g++;
      end
    end
    chk("arb.count", 32'(n_g), 32'd4);
    for (int i = 0; i < n_g; i++) begin
`ifdef DATAMEM_ARB_RR_EN
      chk("arb.grant", 32'(g_id[i]), 32'(i % 2));
`else
      chk("arb.grant", 32'(g_id[i]), 32'd0);
`endif
      if (i > 0) chk("arb.interval", 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
      $display("txn arb grant=%0d cycle=%0d", g_id[i], g_cyc[i]);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    bus.rsp_ready = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port access controller for the byte-addressed 128 KiB data memory. It arbitrates load/store requests from the CPU memory stage (requester 0) and the debug/loader port (requester 1). It converts each accepted byte, half or word access into one word-aligned, byte-enabled memory cycle, and returns sign- or zero-extended read data or a write acknowledge through a per-requester response handshake.

## Interface
- ADDR_W, 17: byte-address width of the memory (2^17 bytes).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [1:0]  request present, one bit per requester.
- req_ready  out  [1:0]  request accepted this cycle.
- req_wen  in  [1:0]  1 = store, 0 = load.
- req_size  in  2×2  size per requester: 00 byte, 01 half, 10 word; 11 is illegal.
- req_signed  in  [1:0]  sign-extend load data.
- req_addr  in  2×32  byte address.
- req_wdata  in  2×32  store data, right-aligned.
- rsp_valid  out  [1:0]  response present.
- rsp_ready  in  [1:0]  response consumed.
- rsp_rdata  out  32  load data, shared by both requesters, qualified by rsp_valid.
- rsp_err  out  1  access faulted, qualified by rsp_valid.
- mem_en  out  1  memory cycle strobe.
- mem_wen  out  1  memory write.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_addr  out  ADDR_W-2  word index.
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  read word, valid the cycle after mem_en.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one access is in flight at a time.
- IDLE: when any req_valid is high, grant one requester. req_ready[g] is asserted combinationally in the same cycle, and addr/size/wen/signed/wdata/id are captured.
- Fault check happens at acceptance:
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0),
  - size 11,
  - any of req_addr[31:ADDR_W] nonzero.
- A faulted request goes IDLE→RESP with rsp_err=1 and rsp_rdata=0. No memory cycle is issued.
- A legal request goes IDLE→ISSUE:
  - mem_en=1 for exactly one cycle; mem_wen=req_wen.
  - mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111.
  - mem_wdata: the byte or half is replicated into all lanes.
- ISSUE→WAIT unconditionally.
- WAIT→RESP: the lane selected by addr[1:0] is extracted from mem_rdata and extended per size/signed, then registered into rsp_rdata. For stores, rsp_rdata=0.
- RESP: rsp_valid[id]=1 and is held stable until rsp_ready[id]. Then go to IDLE, which can accept a new request the following cycle.
- Granted request data must be held by the requester only until req_ready; the block does not sample it afterwards.

## Timing
- Reset values: state IDLE, all req_ready/rsp_valid 0, mem_en/mem_wen 0, mem_be 0, mem_addr 0, mem_wdata 0, rsp_rdata 0, rsp_err 0, last-grant pointer = 1.
- Legal access, accepted in cycle N:
  - mem_en high in N+1;
  - rsp_valid high from N+3;
  - minimum issue interval is 4 cycles.
- Faulted access accepted in cycle N: rsp_valid high from N+1.
- rsp_valid with rsp_ready high in the same cycle: the response retires and IDLE is reached the next cycle.
- req_ready is never asserted outside IDLE or for more than one requester.
- Reset asserted mid-access: asynchronous return to IDLE. mem_en/mem_wen drop immediately and any pending response is discarded. A store already presented in ISSUE may or may not have been written.

## Configuration
- DATAMEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, grant the requester not in the last-grant pointer.
  - The pointer updates on every grant.
- Not defined: fixed priority; requester 0 always wins ties and the pointer is unused (optimised away).

## Structure
- datamem_pkg holds:
  - size enum (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10),
  - FSM state enum,
  - a request struct (wen, size, signed, addr, wdata).
- Sub-module datamem_lane_fmt: purely combinational. Generates byte enables and replicated write data, and performs read lane extraction with sign/zero extension. It is instantiated once.

## Test plan
- Reset then req0 load word addr 0x00000010, memory word 0xDEADBEEF → mem_en at N+1 with mem_addr 0x4, be 1111; rsp_valid[0] at N+3, rdata 0xDEADBEEF, err 0.
- req1 store byte 0xA5 addr 0x00000003 → be 1000, mem_wdata 0xA5A5A5A5; read-back as signed byte returns 0xFFFFFFA5, unsigned returns 0x000000A5.
- Load half addr 0x00000001 → no mem_en; rsp_valid at N+1, err 1, rdata 0. Load word addr 0x00020000 → err 1.
- Both requesters valid every cycle, RR_EN defined → grants alternate 0,1,0,1. Without the macro → only requester 0 is granted while it stays valid.
- Hold rsp_ready[0]=0 for 5 cycles → rsp_valid/rsp_rdata stable; req1 not accepted until the cycle after the handshake.
- Assert rst_n low during ISSUE → mem_en 0 and state IDLE immediately; no rsp_valid after release.
